// File: rtl/syrup_mem_tester_pkg.sv
// Shared constants and the data-pattern generator for the Syrup memory tester.
package syrup_mem_tester_pkg;

    localparam int unsigned ERR_W = 16;
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_WRITE = 3'd1;
    localparam logic [2:0] ST_READ  = 3'd2;
    localparam logic [2:0] ST_DRAIN = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    localparam logic [1:0] MODE_COUNT = 2'd0;
    localparam logic [1:0] MODE_ADDR  = 2'd1;
    localparam logic [1:0] MODE_NADDR = 2'd2;
    localparam logic [1:0] MODE_RSVD  = 2'd3;

    // Pattern for word idx at addr; the caller truncates/extends to W_D.
    // ~address is taken over the address width only, so it zero-extends.
    function automatic logic [63:0] pattern_word(
        input logic [1:0]  mode,
        input logic [63:0] idx,
        input logic [63:0] seed,
        input logic [63:0] addr,
        input logic [63:0] addr_mask
    );
        logic [63:0] r;
        case (mode)
            MODE_ADDR:  r = addr & addr_mask;
            MODE_NADDR: r = ~addr & addr_mask;
            default:    r = idx + seed;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/syrup_mem_tester_checker.sv
// Per-port read checker: delays {valid, expected} by READ_LATENCY cycles and
// flags a mismatch against the memory's Q in the cycle the data is due.
module syrup_mem_tester_checker
    import syrup_mem_tester_pkg::*;
#(
    parameter int unsigned W_D          = 32,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           VALID_IN,
    input  logic [W_D-1:0] EXP_IN,
    input  logic [W_D-1:0] Q,
    output logic           MISMATCH
);

    logic [READ_LATENCY-1:0] vld_q;
    logic [W_D-1:0]          exp_q [READ_LATENCY];

    // Valid-bit shift register; cleared by reset so in-flight reads are dropped.
    always_ff @(posedge CLK) begin
        if (RST) begin
            vld_q <= '0;
        end else begin
            vld_q[0] <= VALID_IN;
            for (int unsigned i = 1; i < READ_LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
            end
        end
    end

    // Expected-data shift register, qualified only by the valid bits.
    always_ff @(posedge CLK) begin
        exp_q[0] <= EXP_IN;
        for (int unsigned i = 1; i < READ_LATENCY; i++) begin
            exp_q[i] <= exp_q[i-1];
        end
    end

    assign MISMATCH = vld_q[READ_LATENCY-1] && (Q != exp_q[READ_LATENCY-1]);

endmodule

// File: rtl/syrup_mem_tester.sv
// N-port memory exerciser: writes a pattern over a region, reads it back and
// counts mismatching words. Every output is a register; next values are
// computed combinationally from the next state so outputs track the FSM.
module syrup_mem_tester
    import syrup_mem_tester_pkg::*;
#(
    parameter int unsigned NUM_PORTS    = 2,
    parameter int unsigned W_A          = 24,
    parameter int unsigned W_D          = 32,
    parameter int unsigned LED_WIDTH    = 8,
    parameter logic [63:0] BASE_ADDR    = 64'd0,
    parameter int unsigned NUM_WORDS    = 256,
    parameter int unsigned STRIDE       = 4,
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned SEED         = 0
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       START,
    input  logic [1:0]                 MODE,
    output logic                       BUSY,
    output logic                       DONE,
    output logic                       PASS,
    output logic [ERR_W-1:0]           ERR_COUNT,
    output logic [LED_WIDTH-1:0]       LED,
    output logic [NUM_PORTS*W_A-1:0]   MEM_ADDR,
    output logic [NUM_PORTS*W_D-1:0]   MEM_D,
    output logic [NUM_PORTS-1:0]       MEM_WE,
    output logic [NUM_PORTS-1:0]       MEM_RE,
    input  logic [NUM_PORTS*W_D-1:0]   MEM_Q
);

    localparam int unsigned BEATS     = NUM_WORDS / NUM_PORTS;
    localparam logic [63:0] ADDR_MASK = (W_A >= 64) ? '1 : ((64'd1 << W_A) - 64'd1);

    logic [2:0]  state_q, state_d;
    logic [31:0] beat_q, beat_d;
    logic [1:0]  mode_q, mode_d;
    logic        clr_err;

    logic [NUM_PORTS-1:0]     we_d, re_d;
    logic [NUM_PORTS*W_A-1:0] addr_d;
    logic [NUM_PORTS*W_D-1:0] data_d, exp_d, exp_q;
    logic [NUM_PORTS-1:0]     mismatch;

    logic [31:0]          hit_cnt, err_sum;
    logic [ERR_W-1:0]     err_base, err_d;
    logic                 busy_d, done_d, pass_d;
    logic [LED_WIDTH-1:0] led_d;

    // FSM next state and beat counter; the beat counter doubles as the drain timer.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        mode_d  = mode_q;
        clr_err = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (START) begin
                    state_d = ST_WRITE;
                    beat_d  = '0;
                    mode_d  = MODE;
                    clr_err = 1'b1;
                end
            end
            ST_WRITE: begin
                if (beat_q == BEATS - 1) begin
                    state_d = ST_READ;
                    beat_d  = '0;
                end else begin
                    beat_d = beat_q + 32'd1;
                end
            end
            ST_READ: begin
                if (beat_q == BEATS - 1) begin
                    state_d = ST_DRAIN;
                    beat_d  = '0;
                end else begin
                    beat_d = beat_q + 32'd1;
                end
            end
            ST_DRAIN: begin
                if (beat_q == READ_LATENCY - 1) begin
                    state_d = ST_DONE;
                    beat_d  = '0;
                end else begin
                    beat_d = beat_q + 32'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                beat_d  = '0;
            end
        endcase
    end

    // Per-port address, write data and expected data for the upcoming beat.
    always_comb begin
        logic [63:0] idx, addr_full, pat;
        we_d      = '0;
        re_d      = '0;
        addr_d    = '0;
        data_d    = '0;
        exp_d     = '0;
        idx       = '0;
        addr_full = '0;
        pat       = '0;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            idx       = 64'(beat_d) * 64'(NUM_PORTS) + 64'(p);
            addr_full = (BASE_ADDR + idx * 64'(STRIDE)) & ADDR_MASK;
            pat       = pattern_word(mode_d, idx, 64'(SEED), addr_full, ADDR_MASK);
            if (state_d == ST_WRITE || state_d == ST_READ) begin
                addr_d[p*W_A +: W_A] = W_A'(addr_full);
            end
            if (state_d == ST_WRITE) begin
                we_d[p]              = 1'b1;
                data_d[p*W_D +: W_D] = W_D'(pat);
            end
            if (state_d == ST_READ) begin
                re_d[p]             = 1'b1;
                exp_d[p*W_D +: W_D] = W_D'(pat);
            end
        end
    end

    // Saturating error accumulation of this cycle's mismatch strobes.
    always_comb begin
        hit_cnt = '0;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            hit_cnt = hit_cnt + 32'(mismatch[p]);
        end
        err_base = clr_err ? '0 : ERR_COUNT;
        err_sum  = 32'(err_base) + hit_cnt;
        err_d    = (err_sum > 32'(ERR_MAX)) ? ERR_MAX : err_sum[ERR_W-1:0];
    end

    // Status flags and LED image derived from next-cycle values.
    always_comb begin
        busy_d = (state_d == ST_WRITE) || (state_d == ST_READ) || (state_d == ST_DRAIN);
        done_d = (state_d == ST_DONE);
        pass_d = done_d && (err_d == '0);
        led_d  = {pass_d, done_d, busy_d, err_d[LED_WIDTH-4:0]};
    end

    // State and output registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            beat_q    <= '0;
            mode_q    <= MODE_COUNT;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
            PASS      <= 1'b0;
            ERR_COUNT <= '0;
            LED       <= '0;
            MEM_ADDR  <= '0;
            MEM_D     <= '0;
            MEM_WE    <= '0;
            MEM_RE    <= '0;
            exp_q     <= '0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            mode_q    <= mode_d;
            BUSY      <= busy_d;
            DONE      <= done_d;
            PASS      <= pass_d;
            ERR_COUNT <= err_d;
            LED       <= led_d;
            MEM_ADDR  <= addr_d;
            MEM_D     <= data_d;
            MEM_WE    <= we_d;
            MEM_RE    <= re_d;
            exp_q     <= exp_d;
        end
    end

    for (genvar gp = 0; gp < NUM_PORTS; gp++) begin : g_chk
        syrup_mem_tester_checker #(
            .W_D          (W_D),
            .READ_LATENCY (READ_LATENCY)
        ) u_chk (
            .CLK      (CLK),
            .RST      (RST),
            .VALID_IN (MEM_RE[gp]),
            .EXP_IN   (exp_q[gp*W_D +: W_D]),
            .Q        (MEM_Q[gp*W_D +: W_D]),
            .MISMATCH (mismatch[gp])
        );
    end

endmodule

// File: tb/tb_syrup_mem_tester.sv
// Directed bench for syrup_mem_tester: several configurations, each with a
// small behavioural memory, checked against hand-computed values.
module tb_syrup_mem_tester;

    logic CLK;
    logic RST;
    int   checks;
    int   errors;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // ---------------- A: defaults ----------------
    logic        a_start, a_busy, a_done, a_pass, a_zero;
    logic [1:0]  a_mode, a_we, a_re;
    logic [15:0] a_err;
    logic [7:0]  a_led;
    logic [47:0] a_addr;
    logic [63:0] a_d, a_q;
    logic [31:0] mem_a [256];

    syrup_mem_tester u_a (
        .CLK(CLK), .RST(RST), .START(a_start), .MODE(a_mode),
        .BUSY(a_busy), .DONE(a_done), .PASS(a_pass), .ERR_COUNT(a_err), .LED(a_led),
        .MEM_ADDR(a_addr), .MEM_D(a_d), .MEM_WE(a_we), .MEM_RE(a_re), .MEM_Q(a_q)
    );

    always @(posedge CLK) begin
        for (int p = 0; p < 2; p++)
            if (a_we[p]) mem_a[a_addr[p*24+2 +: 8]] = a_d[p*32 +: 32];
        for (int p = 0; p < 2; p++)
            a_q[p*32 +: 32] <= (a_re[p] && !a_zero) ? mem_a[a_addr[p*24+2 +: 8]] : 32'h0;
    end

    // ---------------- S: SEED=5, word 17 bit 0 flipped on read ----------------
    logic        s_start, s_busy, s_done, s_pass;
    logic [1:0]  s_mode, s_we, s_re;
    logic [15:0] s_err;
    logic [7:0]  s_led;
    logic [47:0] s_addr;
    logic [63:0] s_d, s_q;
    logic [31:0] mem_s [256];

    syrup_mem_tester #(.SEED(5)) u_s (
        .CLK(CLK), .RST(RST), .START(s_start), .MODE(s_mode),
        .BUSY(s_busy), .DONE(s_done), .PASS(s_pass), .ERR_COUNT(s_err), .LED(s_led),
        .MEM_ADDR(s_addr), .MEM_D(s_d), .MEM_WE(s_we), .MEM_RE(s_re), .MEM_Q(s_q)
    );

    always @(posedge CLK) begin
        for (int p = 0; p < 2; p++)
            if (s_we[p]) mem_s[s_addr[p*24+2 +: 8]] = s_d[p*32 +: 32];
        for (int p = 0; p < 2; p++)
            s_q[p*32 +: 32] <= s_re[p] ?
                (mem_s[s_addr[p*24+2 +: 8]] ^ ((s_addr[p*24 +: 24] == 24'd68) ? 32'h1 : 32'h0)) : 32'h0;
    end

    // ---------------- C: 65538 words, memory always returns 0 ----------------
    logic        c_start, c_busy, c_done, c_pass;
    logic [1:0]  c_mode, c_we, c_re;
    logic [15:0] c_err;
    logic [7:0]  c_led;
    logic [47:0] c_addr;
    logic [63:0] c_d, c_q;

    assign c_q = '0;

    syrup_mem_tester #(.NUM_WORDS(65538)) u_c (
        .CLK(CLK), .RST(RST), .START(c_start), .MODE(c_mode),
        .BUSY(c_busy), .DONE(c_done), .PASS(c_pass), .ERR_COUNT(c_err), .LED(c_led),
        .MEM_ADDR(c_addr), .MEM_D(c_d), .MEM_WE(c_we), .MEM_RE(c_re), .MEM_Q(c_q)
    );

    // ---------------- L: one port, 4 words, read latency 3 ----------------
    logic        l_start, l_busy, l_done, l_pass;
    logic [1:0]  l_mode;
    logic [0:0]  l_we, l_re;
    logic [15:0] l_err;
    logic [7:0]  l_led;
    logic [23:0] l_addr;
    logic [31:0] l_din, l_q, l_p0, l_p1;
    logic [31:0] mem_l [4];

    syrup_mem_tester #(.NUM_PORTS(1), .NUM_WORDS(4), .READ_LATENCY(3)) u_l (
        .CLK(CLK), .RST(RST), .START(l_start), .MODE(l_mode),
        .BUSY(l_busy), .DONE(l_done), .PASS(l_pass), .ERR_COUNT(l_err), .LED(l_led),
        .MEM_ADDR(l_addr), .MEM_D(l_din), .MEM_WE(l_we), .MEM_RE(l_re), .MEM_Q(l_q)
    );

    // Data appears exactly three cycles after RE and is 0 in every other cycle.
    always @(posedge CLK) begin
        if (l_we[0]) mem_l[l_addr[3:2]] = l_din;
        l_p0 <= l_re[0] ? mem_l[l_addr[3:2]] : 32'h0;
        l_p1 <= l_p0;
        l_q  <= l_p1;
    end

    // ---------------- W: base near top of address space, 4 words ----------------
    logic        w_start, w_busy, w_done, w_pass;
    logic [1:0]  w_mode, w_we, w_re;
    logic [15:0] w_err;
    logic [7:0]  w_led;
    logic [47:0] w_addr;
    logic [63:0] w_d, w_q;
    logic [31:0] mem_w [4];

    syrup_mem_tester #(.BASE_ADDR(64'hFFFFF8), .NUM_WORDS(4)) u_w (
        .CLK(CLK), .RST(RST), .START(w_start), .MODE(w_mode),
        .BUSY(w_busy), .DONE(w_done), .PASS(w_pass), .ERR_COUNT(w_err), .LED(w_led),
        .MEM_ADDR(w_addr), .MEM_D(w_d), .MEM_WE(w_we), .MEM_RE(w_re), .MEM_Q(w_q)
    );

    always @(posedge CLK) begin
        for (int p = 0; p < 2; p++)
            if (w_we[p]) mem_w[w_addr[p*24+2 +: 2]] = w_d[p*32 +: 32];
        for (int p = 0; p < 2; p++)
            w_q[p*32 +: 32] <= w_re[p] ? mem_w[w_addr[p*24+2 +: 2]] : 32'h0;
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        step();
        step();
        checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %h want 0", a_busy); end
        checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL rst_done: got %h want 0", a_done); end
        checks++; if (a_pass !== 1'b0) begin errors++; $display("FAIL rst_pass: got %h want 0", a_pass); end
        checks++; if (a_err !== 16'h0) begin errors++; $display("FAIL rst_err: got %h want 0", a_err); end
        checks++; if (a_led !== 8'h0) begin errors++; $display("FAIL rst_led: got %h want 0", a_led); end
        checks++; if ({a_we, a_re} !== 4'h0) begin errors++; $display("FAIL rst_we_re: got %h want 0", {a_we, a_re}); end
        checks++; if ({a_addr, a_d} !== 112'h0) begin errors++; $display("FAIL rst_addr_d: got %h want 0", {a_addr, a_d}); end
        checks++; if (l_busy !== 1'b0 || c_done !== 1'b0) begin errors++; $display("FAIL rst_other: got %b%b want 00", l_busy, c_done); end
        RST = 1'b0;
        step();
        step();
        checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL idle_stays: got %h want 0", a_busy); end
    endtask

    task automatic test_basic();
        int busy_cnt;
        busy_cnt = 0;
        a_mode = 2'd1; a_start = 1'b1; step(); a_start = 1'b0;
        for (int n = 1; n <= 258; n++) begin
            if (a_busy) busy_cnt++;
            if (n == 1) begin
                checks++; if (a_we !== 2'b11 || a_re !== 2'b00) begin errors++; $display("FAIL basic_w1_en: got we=%b re=%b want we=11 re=00", a_we, a_re); end
                checks++; if (a_addr !== {24'd4, 24'd0}) begin errors++; $display("FAIL basic_w1_addr: got %h want %h", a_addr, {24'd4, 24'd0}); end
                checks++; if (a_d !== {32'd4, 32'd0}) begin errors++; $display("FAIL basic_w1_data: got %h want %h", a_d, {32'd4, 32'd0}); end
            end
            if (n == 2) begin
                checks++; if (a_addr !== {24'd12, 24'd8}) begin errors++; $display("FAIL basic_w2_addr: got %h want %h", a_addr, {24'd12, 24'd8}); end
            end
            if (n == 128) begin
                checks++; if (a_we !== 2'b11 || a_addr !== {24'd1020, 24'd1016}) begin errors++; $display("FAIL basic_wlast: got we=%b addr=%h want we=11 addr=%h", a_we, a_addr, {24'd1020, 24'd1016}); end
            end
            if (n == 129) begin
                checks++; if (a_re !== 2'b11 || a_we !== 2'b00 || a_addr !== {24'd4, 24'd0}) begin errors++; $display("FAIL basic_r1: got re=%b we=%b addr=%h want re=11 we=00 addr=%h", a_re, a_we, a_addr, {24'd4, 24'd0}); end
            end
            if (n == 257) begin
                checks++; if (a_done !== 1'b0 || a_re !== 2'b00) begin errors++; $display("FAIL basic_drain: got done=%b re=%b want done=0 re=00", a_done, a_re); end
            end
            if (n < 258) step();
        end
        checks++; if (a_done !== 1'b1) begin errors++; $display("FAIL basic_done: got %b want 1", a_done); end
        checks++; if (busy_cnt !== 257) begin errors++; $display("FAIL basic_busy_len: got %0d want 257", busy_cnt); end
        checks++; if (a_pass !== 1'b1 || a_err !== 16'd0) begin errors++; $display("FAIL basic_pass: got pass=%b err=%0d want pass=1 err=0", a_pass, a_err); end
        checks++; if (a_led !== 8'hC0) begin errors++; $display("FAIL basic_led: got %h want c0", a_led); end
        checks++; if ({a_we, a_re, a_addr, a_d} !== 116'h0) begin errors++; $display("FAIL basic_idle_bus: got %h want 0", {a_we, a_re, a_addr, a_d}); end
    endtask

    task automatic test_start_ignored();
        a_mode = 2'd1; a_start = 1'b1; step(); a_start = 1'b0;
        for (int n = 1; n <= 258; n++) begin
            if (n == 1) a_mode = 2'd2;
            if (n == 5) a_start = 1'b1;
            if (n == 6) begin
                a_start = 1'b0;
                checks++; if (a_we !== 2'b11 || a_addr !== {24'd44, 24'd40}) begin errors++; $display("FAIL ign_w6: got we=%b addr=%h want we=11 addr=%h", a_we, a_addr, {24'd44, 24'd40}); end
            end
            if (n == 257) begin
                checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL ign_early_done: got %b want 0", a_done); end
            end
            if (n < 258) step();
        end
        checks++; if (a_done !== 1'b1 || a_pass !== 1'b1 || a_err !== 16'd0) begin errors++; $display("FAIL ign_result: got done=%b pass=%b err=%0d want 1 1 0", a_done, a_pass, a_err); end
    endtask

    task automatic test_zero_read();
        int n;
        a_zero = 1'b1;
        a_mode = 2'd2; a_start = 1'b1; step(); a_start = 1'b0;
        n = 1;
        while (!a_done && n < 400) begin step(); n++; end
        checks++; if (n !== 258) begin errors++; $display("FAIL zero_done_cycle: got %0d want 258", n); end
        checks++; if (a_err !== 16'd256 || a_pass !== 1'b0) begin errors++; $display("FAIL zero_err: got err=%0d pass=%b want 256 0", a_err, a_pass); end
        checks++; if (a_led !== 8'h40) begin errors++; $display("FAIL zero_led: got %h want 40", a_led); end
        a_zero = 1'b0;
    endtask

    task automatic test_mid_reset();
        int n;
        a_zero = 1'b1;
        a_mode = 2'd2; a_start = 1'b1; step(); a_start = 1'b0;
        for (int k = 1; k < 138; k++) step();
        checks++; if (a_err !== 16'd16 || a_busy !== 1'b1) begin errors++; $display("FAIL mrst_pre: got err=%0d busy=%b want 16 1", a_err, a_busy); end
        RST = 1'b1;
        step();
        checks++; if ({a_busy, a_done, a_pass} !== 3'b000 || a_err !== 16'd0 || a_led !== 8'h0) begin errors++; $display("FAIL mrst_status: got b/d/p=%b err=%0d led=%h want 0", {a_busy, a_done, a_pass}, a_err, a_led); end
        checks++; if ({a_we, a_re, a_addr, a_d} !== 116'h0) begin errors++; $display("FAIL mrst_bus: got %h want 0", {a_we, a_re, a_addr, a_d}); end
        RST = 1'b0;
        step();
        checks++; if (a_err !== 16'd0) begin errors++; $display("FAIL mrst_pipe_clear: got err=%0d want 0", a_err); end
        step(); step();
        checks++; if (a_busy !== 1'b0 || a_re !== 2'b00) begin errors++; $display("FAIL mrst_idle: got busy=%b re=%b want 0 00", a_busy, a_re); end
        a_zero = 1'b0;
        a_mode = 2'd1; a_start = 1'b1; step(); a_start = 1'b0;
        n = 1;
        while (!a_done && n < 400) begin step(); n++; end
        checks++; if (n !== 258 || a_pass !== 1'b1 || a_err !== 16'd0) begin errors++; $display("FAIL mrst_rerun: got cyc=%0d pass=%b err=%0d want 258 1 0", n, a_pass, a_err); end
    endtask

    task automatic test_seed_flip();
        int n;
        s_mode = 2'd0; s_start = 1'b1; step(); s_start = 1'b0;
        checks++; if (s_d !== {32'd6, 32'd5} || s_we !== 2'b11) begin errors++; $display("FAIL seed_w1: got d=%h we=%b want %h 11", s_d, s_we, {32'd6, 32'd5}); end
        n = 1;
        while (!s_done && n < 400) begin step(); n++; end
        checks++; if (n !== 258) begin errors++; $display("FAIL seed_done_cycle: got %0d want 258", n); end
        checks++; if (s_err !== 16'd1 || s_pass !== 1'b0) begin errors++; $display("FAIL seed_err: got err=%0d pass=%b want 1 0", s_err, s_pass); end
        checks++; if (s_led !== 8'h41) begin errors++; $display("FAIL seed_led: got %h want 41", s_led); end
    endtask

    task automatic test_latency();
        int n;
        int busy_cnt;
        busy_cnt = 0;
        l_mode = 2'd2; l_start = 1'b1; step(); l_start = 1'b0;
        n = 1;
        while (!l_done && n < 50) begin
            if (l_busy) busy_cnt++;
            if (n == 4) begin
                checks++; if (l_we !== 1'b1 || l_addr !== 24'd12 || l_din !== 32'h00FFFFF3) begin errors++; $display("FAIL lat_wlast: got we=%b addr=%h d=%h want 1 00000c 00fffff3", l_we, l_addr, l_din); end
            end
            if (n == 5) begin
                checks++; if (l_re !== 1'b1 || l_we !== 1'b0 || l_addr !== 24'd0) begin errors++; $display("FAIL lat_r1: got re=%b we=%b addr=%h want 1 0 000000", l_re, l_we, l_addr); end
            end
            step(); n++;
        end
        checks++; if (n !== 12) begin errors++; $display("FAIL lat_done_cycle: got %0d want 12", n); end
        checks++; if (busy_cnt !== 11) begin errors++; $display("FAIL lat_busy_len: got %0d want 11", busy_cnt); end
        checks++; if (l_pass !== 1'b1 || l_err !== 16'd0) begin errors++; $display("FAIL lat_pass: got pass=%b err=%0d want 1 0", l_pass, l_err); end
    endtask

    task automatic test_wrap();
        int n;
        w_mode = 2'd1; w_start = 1'b1; step(); w_start = 1'b0;
        checks++; if (w_addr !== {24'hFFFFFC, 24'hFFFFF8} || w_d !== {32'h00FFFFFC, 32'h00FFFFF8}) begin errors++; $display("FAIL wrap_w1: got addr=%h d=%h want fffffcfffff8 00fffffc00fffff8", w_addr, w_d); end
        step();
        checks++; if (w_addr !== {24'h4, 24'h0} || w_d !== {32'h4, 32'h0}) begin errors++; $display("FAIL wrap_w2: got addr=%h d=%h want 000004000000 0000000400000000", w_addr, w_d); end
        step();
        checks++; if (w_re !== 2'b11 || w_addr !== {24'hFFFFFC, 24'hFFFFF8}) begin errors++; $display("FAIL wrap_r1: got re=%b addr=%h want 11 fffffcfffff8", w_re, w_addr); end
        n = 3;
        while (!w_done && n < 50) begin step(); n++; end
        checks++; if (n !== 6) begin errors++; $display("FAIL wrap_done_cycle: got %0d want 6", n); end
        checks++; if (w_pass !== 1'b1 || w_err !== 16'd0 || w_led !== 8'hC0) begin errors++; $display("FAIL wrap_pass: got pass=%b err=%0d led=%h want 1 0 c0", w_pass, w_err, w_led); end
    endtask

    task automatic test_saturate();
        int n;
        c_mode = 2'd2; c_start = 1'b1; step(); c_start = 1'b0;
        n = 1;
        while (!c_done && n < 70000) begin step(); n++; end
        checks++; if (n !== 65540) begin errors++; $display("FAIL sat_done_cycle: got %0d want 65540", n); end
        checks++; if (c_err !== 16'hFFFF || c_pass !== 1'b0) begin errors++; $display("FAIL sat_err: got err=%h pass=%b want ffff 0", c_err, c_pass); end
        checks++; if (c_led !== 8'h5F) begin errors++; $display("FAIL sat_led: got %h want 5f", c_led); end
    endtask

    initial begin
        checks = 0; errors = 0;
        RST = 1'b1; a_zero = 1'b0;
        a_start = 1'b0; s_start = 1'b0; c_start = 1'b0; l_start = 1'b0; w_start = 1'b0;
        a_mode = 2'd0; s_mode = 2'd0; c_mode = 2'd0; l_mode = 2'd0; w_mode = 2'd0;
        test_reset();
        test_basic();
        test_start_ignored();
        test_zero_read();
        test_mid_reset();
        test_seed_flip();
        test_latency();
        test_wrap();
        test_saturate();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "time limit");
    end

endmodule

// File: doc/syrup_mem_tester.md
# syrup_mem_tester

Self-checking memory traffic generator and verifier for Syrup memory instances with one or more ports. It generalises the fixed-pattern user-logic exercisers to N ports with selectable data patterns. It performs a write pass over a configurable region, then a read-back pass comparing returned data against regenerated expected values. It sits in user logic in place of a hand-written exerciser and connects directly to the Syrup memory's per-port ADDR/D/WE/RE/Q pins.

## Interface
- NUM_PORTS, 2, memory ports driven in parallel (≥1).
- W_A, 24, address width.
- W_D, 32, data width.
- LED_WIDTH, 8, status LED width (≥4).
- BASE_ADDR, 0, byte address of word 0.
- NUM_WORDS, 256, words tested; must be a multiple of NUM_PORTS.
- STRIDE, 4, byte distance between consecutive words.
- READ_LATENCY, 1, cycles from RE high to valid Q (≥1).
- SEED, 0, offset added in counter mode.
- CLK  in  1  single clock; all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- START  in  1  level; sampled only in IDLE or DONE.
- MODE  in  2  pattern: 0 = counter (i+SEED), 1 = address, 2 = ~address, 3 = treated as 0; latched at START.
- BUSY  out  1  test in progress.
- DONE  out  1  sticky completion flag.
- PASS  out  1  DONE and ERR_COUNT==0.
- ERR_COUNT  out  16  mismatching words, saturating.
- LED  out  LED_WIDTH  bit LED_WIDTH-1 = PASS, bit LED_WIDTH-2 = DONE, bit LED_WIDTH-3 = BUSY, low bits = ERR_COUNT[LED_WIDTH-4:0].
- MEM_ADDR  out  NUM_PORTS*W_A  port p at [p*W_A +: W_A].
- MEM_D  out  NUM_PORTS*W_D  write data, per-port slices.
- MEM_WE  out  NUM_PORTS  write enables.
- MEM_RE  out  NUM_PORTS  read enables.
- MEM_Q  in  NUM_PORTS*W_D  read data.

## Operation
- States: IDLE → WRITE → READ → DRAIN → DONE. START in DONE goes to WRITE.
- On START: latch MODE, clear ERR_COUNT and DONE, and zero the beat counter b. Beats per pass: W = NUM_WORDS/NUM_PORTS.
- At beat b, port p handles word i = b*NUM_PORTS + p.
  - Address = (BASE_ADDR + i*STRIDE) mod 2^W_A. Overflow wraps silently.
  - Pattern = function(MODE, i, address), truncated or zero-extended to W_D.
- WRITE: all MEM_WE high, MEM_D = pattern, MEM_RE low. After W beats, go to READ with b = 0.
- READ: all MEM_RE high, MEM_WE low. Expected data and a valid bit enter a READ_LATENCY-deep pipeline per port. After W beats, go to DRAIN.
- DRAIN: hold READ_LATENCY cycles with RE/WE low, then go to DONE.
- Compare: when a pipeline output is valid, each port with MEM_Q ≠ expected adds 1.
  - Adds up to NUM_PORTS per cycle.
  - ERR_COUNT saturates at 16'hFFFF.
- START while BUSY is ignored. START held high in DONE restarts immediately.
- Outside WRITE/READ, MEM_WE, MEM_RE, MEM_ADDR and MEM_D are 0.

## Timing
- All outputs are registered.
- START high in IDLE at edge k:
  - first write beat is visible at cycle k+1;
  - read beats run k+1+W … k+2W;
  - DONE rises at k+1+2W+READ_LATENCY.
- BUSY is high exactly 2W+READ_LATENCY cycles.
- Q for the read issued at cycle c is sampled at cycle c+READ_LATENCY.
- RST (any state, including mid-pass):
  - next cycle state is IDLE;
  - BUSY, DONE, PASS, ERR_COUNT, LED, MEM_* = 0;
  - compare pipeline valid bits are cleared.
  - Memory contents are not restored.
- The write→read turnaround has no gap cycle. The first read beat follows the last write beat directly.

## Structure
- Package syrup_mem_tester_pkg: state encoding, MODE codes, pattern function (mode, index, address → W_D data), ERR_COUNT width constant.
- Sub-module syrup_mem_tester_checker: one per port, generated NUM_PORTS times. It holds the READ_LATENCY shift register of {valid, expected} and outputs a 1-bit mismatch strobe.
- Top level holds the FSM, beat counter, address/pattern generation and the saturating error adder.

## Test plan
Bench uses a behavioural N-port memory with parameterised read latency.
- Defaults, MODE=1, START pulse → 128 write beats then 128 read beats. Port 0 writes addresses 0, 8, …; port 1 writes 4, 12, …. DONE at cycle 258 after START; PASS=1, ERR_COUNT=0.
- MODE=0, SEED=5, memory model flips bit 0 of word 17 on read → ERR_COUNT=1, PASS=0, LED[0]=1.
- Memory model returns 0 for all reads, MODE=2, NUM_WORDS=256 → ERR_COUNT=256. Repeat with NUM_WORDS=65538 and a forced error every word → ERR_COUNT saturates at 16'hFFFF.
- READ_LATENCY=3, NUM_PORTS=1, NUM_WORDS=4 → BUSY exactly 11 cycles; Q sampled 3 cycles after each RE; PASS=1.
- RST asserted during the 10th read beat → next cycle all outputs 0, state IDLE. A new START runs the full test and passes.
- START pulsed during WRITE → ignored, no timing change. BASE_ADDR=24'hFFFFF8, NUM_WORDS=4 → addresses wrap to 0 and 4; PASS=1.
